// File: rtl/mmio_periph_pkg.sv
// Shared definitions for the mmio_periph responder: register offsets, FSM states,
// STATUS bit layout and the byte-lane write merge used by every RW register.
package mmio_periph_pkg;

  localparam logic [7:0] OFF_LED    = 8'h00;
  localparam logic [7:0] OFF_BTN    = 8'h04;
  localparam logic [7:0] OFF_TICK   = 8'h08;
  localparam logic [7:0] OFF_CMP    = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;
  localparam logic [7:0] OFF_IRQEN  = 8'h14;

  // STATUS / IRQ_EN share one layout: timer hit in bit 0, buttons above it.
  localparam int STAT_TIMER   = 0;
  localparam int STAT_BTN_LSB = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mmio_periph_btn_sync.sv
// Per-bit two-flop synchronizer for asynchronous buttons, with a one-cycle
// pulse whenever the synchronized level goes from 0 to 1.
module mmio_periph_btn_sync #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_btn,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_rise
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [1:0] r_sync;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_sync <= 2'b00;
        end else begin
          r_sync <= {r_sync[0], i_btn[gi]};
        end
      end

      // Pulse is high in the cycle before the level flop rises, so the
      // STATUS bit and the visible level update on the same edge.
      assign o_level[gi] = r_sync[1];
      assign o_rise[gi]  = r_sync[0] & ~r_sync[1];
    end
  endgenerate

endmodule

// File: rtl/mmio_periph.sv
// Memory-mapped responder: LED register, synchronized buttons with edge-latched
// status, free-running tick counter with compare, and a level interrupt.
module mmio_periph
  import mmio_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          LED_WIDTH = 8,
  parameter int          BTN_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic [3:0]           mem_wstrb,
  output logic [31:0]          mem_rdata,
  output logic [LED_WIDTH-1:0] led,
  input  logic [BTN_WIDTH-1:0] btn,
  output logic                 irq
);

  localparam int SW = BTN_WIDTH + 1;

  state_t               r_state;
  logic                 r_ready;
  logic [31:0]          r_rdata;
  logic [LED_WIDTH-1:0] r_led;
  logic [31:0]          r_tick;
  logic [31:0]          r_cmp;
  logic [SW-1:0]        r_status;
  logic [SW-1:0]        r_irq_en;
  logic                 r_irq;

  logic [BTN_WIDTH-1:0] w_btn_level;
  logic [BTN_WIDTH-1:0] w_btn_rise;
  logic                 w_in_window;
  logic                 w_accept;
  logic                 w_we;
  logic [7:0]           w_off;
  logic [31:0]          w_rd_val;
  logic [31:0]          w_wr_val;
  logic [31:0]          w_wmask_data;
  logic [SW-1:0]        w_set;
  logic [SW-1:0]        w_clr;
  logic [SW-1:0]        w_status_next;
  logic                 w_unused;

  mmio_periph_btn_sync #(.WIDTH(BTN_WIDTH)) u_btn_sync (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (btn),
    .o_level (w_btn_level),
    .o_rise  (w_btn_rise)
  );

  assign w_in_window = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]);
  assign w_accept    = (r_state == IDLE) && w_in_window;
  assign w_we        = w_accept && (mem_wstrb != 4'b0000);
  assign w_off       = {mem_addr[7:2], 2'b00};

  always_comb begin
    w_rd_val = 32'd0;
    case (w_off)
      OFF_LED:    w_rd_val = 32'(r_led);
      OFF_BTN:    w_rd_val = 32'(w_btn_level);
      OFF_TICK:   w_rd_val = r_tick;
      OFF_CMP:    w_rd_val = r_cmp;
      OFF_STATUS: w_rd_val = 32'(r_status);
      OFF_IRQEN:  w_rd_val = 32'(r_irq_en);
      default:    w_rd_val = 32'd0;
    endcase
  end

  // The read value doubles as the old contents for the byte merge; bits above a
  // register's width are dropped when the merged word is stored back.
  assign w_wr_val     = merge_bytes(w_rd_val, mem_wdata, mem_wstrb);
  assign w_wmask_data = merge_bytes(32'd0, mem_wdata, mem_wstrb);

  assign w_set = {w_btn_rise, (r_tick == r_cmp)};
  assign w_clr = (w_we && (w_off == OFF_STATUS)) ? w_wmask_data[SW-1:0] : '0;
  assign w_status_next = (r_status & ~w_clr) | w_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led    <= '0;
      r_tick   <= 32'd0;
      r_cmp    <= 32'hFFFF_FFFF;
      r_status <= '0;
      r_irq_en <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_tick   <= (w_we && (w_off == OFF_TICK)) ? w_wr_val : r_tick + 32'd1;
      r_status <= w_status_next;
      r_irq    <= |(r_status & r_irq_en);
      if (w_we && (w_off == OFF_LED))   r_led    <= w_wr_val[LED_WIDTH-1:0];
      if (w_we && (w_off == OFF_CMP))   r_cmp    <= w_wr_val;
      if (w_we && (w_off == OFF_IRQEN)) r_irq_en <= w_wr_val[SW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          r_rdata <= 32'd0;
          if (w_accept) begin
            r_ready <= 1'b1;
            r_rdata <= w_rd_val;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_ready <= 1'b0;
          r_rdata <= 32'd0;
          r_state <= DONE;
        end
        DONE: begin
          r_ready <= 1'b0;
          r_rdata <= 32'd0;
          // Wait for the initiator to drop valid so one request yields one pulse.
          if (!mem_valid) r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_rdata <= 32'd0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_ready = r_ready;
  assign mem_rdata = r_rdata;
  assign led       = r_led;
  assign irq       = r_irq;

  assign w_unused = ^{mem_addr[1:0], w_wmask_data};

endmodule

// File: doc/mmio_periph.md
Name: mmio_periph

Overview:
Memory-mapped peripheral on the 32-bit valid/ready memory bus (mem_valid, mem_ready, mem_addr, mem_wdata, mem_wstrb, mem_rdata). Acts as the responder that our LED/step sequencers and the future CPU initiate against. It provides an LED register, synchronized buttons with edge-latched status, and a free-running tick counter with compare. The compare replaces hand-rolled 1 s wait loops in initiators.

Parameters:
BASE_ADDR, 32'h1000_0000, window base; the block decodes when mem_addr[31:8] == BASE_ADDR[31:8].
LED_WIDTH, 8, width of the LED register and output.
BTN_WIDTH, 7, width of the button input; must be ≤ 31.

Ports:
clk  in  1  system clock (25 MHz on board)
reset  in  1  synchronous, active-high reset
mem_valid  in  1  initiator request
mem_ready  out  1  one-cycle response pulse
mem_addr  in  32  byte address; bits [1:0] ignored
mem_wdata  in  32  write data
mem_wstrb  in  4  byte enables; 4'b0000 = read
mem_rdata  out  32  read data, valid while mem_ready=1, else 0
led  out  LED_WIDTH  LED register
btn  in  BTN_WIDTH  raw asynchronous buttons
irq  out  1  registered, equals |(STATUS & IRQ_EN)

Behaviour:
- Reset values: mem_ready=0, mem_rdata=0, led=0, irq=0, TICK=0, CMP=32'hFFFF_FFFF, STATUS=0, IRQ_EN=0, synchronizer flops=0, FSM=IDLE.
- Register map, offset = mem_addr[7:0]:
  - 0x00 LED: RW, bits [LED_WIDTH-1:0].
  - 0x04 BTN: RO, synchronized level.
  - 0x08 TICK: RW.
  - 0x0C CMP: RW.
  - 0x10 STATUS: W1C. Bit0 = timer hit; bits [BTN_WIDTH:1] = button rising edges.
  - 0x14 IRQ_EN: RW, same bit layout as STATUS.
  - Other in-window offsets: read 0, write ignored, still acknowledged.
- Writes are per byte: each mem_wstrb[i] updates byte i of the target only. Bits outside a register's width are ignored on write and read as 0.
- FSM has three states: IDLE, RESP, DONE.
  - IDLE: if mem_valid and in-window at edge N, latch the address and perform the write/read-sample at edge N. Go to RESP.
  - RESP: mem_ready=1 and mem_rdata=sampled value for exactly cycle N+1. Go to DONE.
  - DONE: stay until mem_valid is sampled 0, then go to IDLE.
  - Latency is fixed at 1 cycle. mem_ready is never asserted 2 consecutive cycles. A back-to-back request needs at least 1 cycle with mem_valid low.
- Out-of-window requests: no response. mem_ready stays 0, FSM stays in IDLE, no state changes.
- Read of TICK returns the value held at edge N (pre-increment).
- The TICK counter increments every cycle and wraps from 0xFFFF_FFFF to 0. A TICK write at edge N loads the written bytes, overriding that cycle's increment.
- STATUS[0] sets on the edge where TICK == CMP, using the pre-increment value.
- Buttons pass through a 2-flop synchronizer. A 0→1 transition of a synchronized bit sets its STATUS bit.
- STATUS set and W1C on the same edge: set wins.
- irq is registered from the updated STATUS/IRQ_EN, so it lags by one cycle.
- Reset asserted mid-transaction: FSM returns to IDLE and mem_ready=0 next cycle. The initiator must reissue the request.

Decomposition:
- Package mmio_periph_pkg holds:
  - register offset constants (OFF_LED, OFF_BTN, OFF_TICK, OFF_CMP, OFF_STATUS, OFF_IRQEN);
  - FSM state enum (IDLE, RESP, DONE);
  - STATUS bit index constants.
- Sub-module btn_sync: per-bit 2-flop synchronizer plus rising-edge pulse, parameterized on width. Instantiated once.

Test Plan:
- Write LED: write 0x0000_00A5 to BASE+0x00 with wstrb=4'b1111 → mem_ready 1 cycle after valid, led=0xA5. Read back → rdata=0x0000_00A5.
- Byte strobes: write CMP=0x1122_3344 (full), then 0xFFFF_FFFF with wstrb=4'b0100 → CMP reads 0x11FF_3344.
- Timer hit: reset, write CMP=100, IRQ_EN=1 → STATUS[0] sets on the edge where TICK==100, irq=1 the next cycle. Write STATUS 0x1 → STATUS[0]=0 and irq drops. A clear on the hit edge leaves STATUS[0]=1.
- Button edge: raise btn[2] → BTN reads bit2=1 after 2 cycles and STATUS bit3 sets. Holding btn[2] high after W1C does not re-set STATUS bit3.
- Handshake: hold mem_valid high for 4 cycles → exactly one mem_ready pulse. Out-of-window address 0x2000_0000 → mem_ready never asserted and led unchanged.
- Reset mid-op: assert reset in the RESP cycle → mem_ready=0 next cycle, all registers at reset values, TICK restarts at 0.
